load_return_unit: RTL and testbench

//   Load-side counterpart of the store path (byte-enable generation + write-data alignment).

---
 rtl/load_return_unit.sv | 152 +++++++++++++++
 tb/tb_load_return_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_return_unit.sv
// load_return_unit
//   Load-side memory unit. Accepts one decoded load at a time and issues a
//   word-aligned read to the data-memory port. It shifts the returned word
//   down to the addressed byte lane, then sign- or zero-extends it. The
//   result goes out with its destination tag on a valid/ready writeback port.
//   A misaligned request skips the memory and returns wb_misalign=1 with
//   wb_data=0.
//
//   Encodings:
//     req_memsz : 2'b00 byte, 2'b01 half, 2'b10 word (2'b11 handled as word)
//     req_ldext : 1'b1 sign-extend, 1'b0 zero-extend
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     flush             kill the in-flight load
//     req_*             load request (valid/ready, addr, memsz, ldext, tag)
//     mem_*             data-memory read port (read strobe, word address,
//                       byte mask, read data, single-cycle response)
//     wb_*              writeback result (valid/ready, data, tag, misalign)
module load_return_unit #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_memsz,
    input  logic             req_ldext,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_read,
    output logic [31:0]      mem_address,
    output logic [3:0]       mem_mbe,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_resp,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_misalign
);

    localparam logic [1:0] MEM_B   = 2'b00;
    localparam logic [1:0] MEM_H   = 2'b01;
    localparam logic       LDEXT_S = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, WB, DRAIN} state_t;

    state_t      state, next_state;
    logic [31:0] addr_p0;
    logic [1:0]  memsz_p0;
    logic        ldext_p0;
    logic        accept;
    logic        req_misaligned;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        if (sz == MEM_B)      is_misaligned = 1'b0;
        else if (sz == MEM_H) is_misaligned = off[0];
        else                  is_misaligned = (off != 2'b00);
    endfunction

    function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
        if (sz == MEM_B)      byte_mask = 4'b0001 << off;
        else if (sz == MEM_H) byte_mask = off[1] ? 4'b1100 : 4'b0011;
        else                  byte_mask = 4'b1111;
    endfunction

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] align_extend(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  sz,
                                                 input logic        ext);
        logic [31:0]        shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        shifted = word >> {off, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        if (sz == MEM_B) begin
            if (ext == LDEXT_S) align_extend = 32'(byte_s);
            else                align_extend = {24'd0, shifted[7:0]};
        end else if (sz == MEM_H) begin
            if (ext == LDEXT_S) align_extend = 32'(half_s);
            else                align_extend = {16'd0, shifted[15:0]};
        end else begin
            align_extend = shifted;
        end
    endfunction

    // A flush in IDLE blocks acceptance of a request presented in the same cycle.
    assign accept         = (state == IDLE) && req_valid && !flush;
    assign req_misaligned = is_misaligned(req_memsz, req_addr[1:0]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (accept) next_state = req_misaligned ? WB : REQ;
            // A flush that coincides with the response discards the data directly.
            REQ: begin
                if (flush)         next_state = mem_resp ? IDLE : DRAIN;
                else if (mem_resp) next_state = WB;
            end
            WB:    if (wb_ready || flush) next_state = IDLE;
            // The read cannot be aborted. Wait it out and throw the data away.
            DRAIN: if (mem_resp) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture and writeback result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p0     <= '0;
            memsz_p0    <= '0;
            ldext_p0    <= 1'b0;
            wb_data     <= '0;
            wb_tag      <= '0;
            wb_misalign <= 1'b0;
        end else begin
            if (accept) begin
                addr_p0     <= req_addr;
                memsz_p0    <= req_memsz;
                ldext_p0    <= req_ldext;
                wb_tag      <= req_tag;
                wb_misalign <= req_misaligned;
                wb_data     <= '0;
            end else if ((state == REQ) && mem_resp && !flush) begin
                wb_data <= align_extend(mem_rdata, addr_p0[1:0], memsz_p0, ldext_p0);
            end
        end
    end

    // Output logic
    always_comb begin
        req_ready   = (state == IDLE);
        mem_read    = (state == REQ) || (state == DRAIN);
        mem_address = {addr_p0[31:2], 2'b00};
        mem_mbe     = 4'b0000;
        if ((state == REQ) || (state == DRAIN))
            mem_mbe = byte_mask(memsz_p0, addr_p0[1:0]);
        wb_valid    = (state == WB);
    end

endmodule

// File: tb/tb_load_return_unit.sv
module tb_load_return_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_memsz;
    logic        req_ldext;
    logic [5:0]  req_tag;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [5:0]  wb_tag;
    logic        wb_misalign;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_wb;

    load_return_unit #(.TAG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_memsz(req_memsz), .req_ldext(req_ldext), .req_tag(req_tag),
        .mem_read(mem_read), .mem_address(mem_address), .mem_mbe(mem_mbe),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    // Reference model: load semantics from byte counts and integer arithmetic.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_mis(input logic [31:0] addr, input logic [1:0] sz);
        int off;
        off = int'(addr[1:0]);
        return (off % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_mbe(input logic [31:0] addr, input logic [1:0] sz);
        int m;
        m = ((1 << nbytes(sz)) - 1) << int'(addr[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] addr, input logic [1:0] sz,
                                               input logic ext, input logic [31:0] rdata);
        longint span, v;
        span = longint'(1) << (8 * nbytes(sz));
        v    = (longint'(rdata) >> (8 * int'(addr[1:0]))) & (span - 1);
        if (ext && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic [1:0] sz, input logic ext,
                         input logic [5:0] tag);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_addr = addr; req_memsz = sz; req_ldext = ext; req_tag = tag;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_tag = 6'($urandom);
    endtask

    // Full transaction: request, memory reply after `delay` extra cycles,
    // writeback held for `wbwait` cycles before wb_ready.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] sz, input logic ext,
                           input logic [5:0] tag, input logic [31:0] rdata,
                           input int delay, input int wbwait);
        logic        mis;
        logic [31:0] expd;
        mis  = model_mis(addr, sz);
        expd = mis ? 32'd0 : model_data(addr, sz, ext, rdata);
        issue(addr, sz, ext, tag);
        if (mis) begin
            chk("mis_no_read", mem_read, 0);
        end else begin
            for (int d = 0; d <= delay; d++) begin
                chk("mem_read", mem_read, 1);
                chk("mem_address", mem_address, {addr[31:2], 2'b00});
                chk("mem_mbe", mem_mbe, model_mbe(addr, sz));
                chk("busy_req", req_ready, 0);
                chk("no_wb_yet", wb_valid, 0);
                if (d == delay) begin mem_resp = 1'b1; mem_rdata = rdata; end
                @(negedge clk);
                mem_resp = 1'b0; mem_rdata = $urandom;
            end
        end
        for (int w = 0; w <= wbwait; w++) begin
            chk("wb_valid", wb_valid, 1);
            chk("wb_data", wb_data, expd);
            chk("wb_tag", wb_tag, tag);
            chk("wb_misalign", wb_misalign, mis);
            chk("read_dropped", mem_read, 0);
            chk("busy_wb", req_ready, 0);
            last_wb = wb_data;
            if (w == wbwait) wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
        end
        chk("wb_done", wb_valid, 0);
        chk("idle_again", req_ready, 1);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_mem_read"}, mem_read, 0);
        chk({name, "_mem_mbe"}, mem_mbe, 0);
        chk({name, "_wb_valid"}, wb_valid, 0);
        chk({name, "_wb_data"}, wb_data, 0);
        chk({name, "_wb_tag"}, wb_tag, 0);
        chk({name, "_wb_misalign"}, wb_misalign, 0);
        chk({name, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_memsz = '0;
        req_ldext = 1'b0; req_tag = '0; mem_rdata = '0; mem_resp = 1'b0; wb_ready = 1'b0;
        last_wb = '0;
        @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;

        // Directed loads
        do_load(32'h103, 2'b00, 1'b1, 6'h2A, 32'h80FF_1234, 0, 0);
        chk("lb_const", last_wb, 32'hFFFF_FF80);
        do_load(32'h102, 2'b01, 1'b0, 6'h11, 32'h9ABC_5678, 0, 1);
        chk("lhu_const", last_wb, 32'h0000_9ABC);
        do_load(32'h102, 2'b01, 1'b1, 6'h12, 32'h9ABC_5678, 1, 0);
        chk("lh_const", last_wb, 32'hFFFF_9ABC);
        do_load(32'h200, 2'b10, 1'b0, 6'h05, 32'hDEAD_BEEF, 5, 2);
        chk("lw_const", last_wb, 32'hDEAD_BEEF);
        do_load(32'h202, 2'b10, 1'b1, 6'h3F, 32'h1234_5678, 0, 0);
        do_load(32'h301, 2'b01, 1'b1, 6'h07, 32'h1234_5678, 0, 0);

        // Flush during REQ, response three cycles later
        issue(32'h300, 2'b10, 1'b0, 6'h01);
        flush = 1'b1;
        chk("flush_req_read", mem_read, 1);
        @(negedge clk);
        flush = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            chk("drain_read", mem_read, 1);
            chk("drain_addr", mem_address, 32'h300);
            chk("drain_no_wb", wb_valid, 0);
            chk("drain_busy", req_ready, 0);
            if (d == 3) begin mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D; end
            @(negedge clk);
            mem_resp = 1'b0;
        end
        chk("drain_done_read", mem_read, 0);
        chk("drain_done_wb", wb_valid, 0);
        chk("drain_done_idle", req_ready, 1);
        @(negedge clk);
        chk("drain_never_wb", wb_valid, 0);

        // Flush and response together in REQ
        issue(32'h104, 2'b10, 1'b0, 6'h02);
        flush = 1'b1; mem_resp = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        flush = 1'b0; mem_resp = 1'b0;
        chk("flushresp_idle", req_ready, 1);
        chk("flushresp_no_wb", wb_valid, 0);
        chk("flushresp_read", mem_read, 0);

        // Flush in WB drops the result
        issue(32'h108, 2'b00, 1'b0, 6'h03);
        mem_resp = 1'b1; mem_rdata = 32'h0000_00AB;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("wbflush_valid_before", wb_valid, 1);
        chk("wbflush_data", wb_data, 32'h0000_00AB);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("wbflush_dropped", wb_valid, 0);
        chk("wbflush_idle", req_ready, 1);

        // Flush and wb_ready together in WB
        issue(32'h10C, 2'b10, 1'b0, 6'h04);
        mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("wbflushrdy_valid", wb_valid, 1);
        flush = 1'b1; wb_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; wb_ready = 1'b0;
        chk("wbflushrdy_done", wb_valid, 0);
        chk("wbflushrdy_idle", req_ready, 1);

        // Flush with a request in IDLE: the request is refused
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h400; req_memsz = 2'b10; req_tag = 6'h09;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("idleflush_ready", req_ready, 1);
        chk("idleflush_read", mem_read, 0);
        chk("idleflush_wb", wb_valid, 0);

        // Reset while the result waits for wb_ready
        issue(32'h201, 2'b00, 1'b1, 6'h15);
        mem_resp = 1'b1; mem_rdata = 32'h0000_F000;
        @(negedge clk);
        mem_resp = 1'b0;
        for (int w = 0; w < 4; w++) begin
            chk("rst_wait_valid", wb_valid, 1);
            chk("rst_wait_data", wb_data, 32'hFFFF_FFF0);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 chk_cleared("async_rst");
        #1 rst = 1'b0;

        // Reset during REQ; the late response arrives in IDLE and is ignored
        issue(32'h204, 2'b10, 1'b0, 6'h16);
        chk("rst_req_read", mem_read, 1);
        #2 rst = 1'b1;
        #1 chk("rst_req_cleared", mem_read, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("stale_resp_wb", wb_valid, 0);
        chk("stale_resp_idle", req_ready, 1);

        do_load(32'h208, 2'b10, 1'b0, 6'h17, 32'h0BAD_F00D, 0, 0);

        // Randomized loads against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = $urandom;
            s = 2'($urandom_range(0, 2));
            do_load(a, s, 1'($urandom), 6'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
